tmds_encoder: RTL and testbench

TMDS_ENCODER -- requirements
Module: tmds_encoder

---
 rtl/tmds_pkg.sv | 29 ++
 rtl/tmds_qm_stage.sv | 23 ++
 rtl/tmds_encoder.sv | 81 ++++++++
 tb/tb_tmds_encoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control/TERC4 symbol tables, disparity width and stage-1 encode helpers
package tmds_pkg;
    localparam int DISP_W = 5;
    localparam logic [9:0] CTRL_SYM [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };
    localparam logic [9:0] TERC4_SYM [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b0, v[i]};
        return n;
    endfunction
    // XNOR chaining is XOR chaining with every step inverted
    function automatic logic [8:0] qm_encode(input logic [7:0] v);
        logic [8:0] q;
        logic xn;
        xn = ones8(v) > 4'd4 || (ones8(v) == 4'd4 && !v[0]);
        q = {~xn, 8'b0};
        q[0] = v[0];
        for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ v[i] ^ xn;
        return q;
    endfunction
endpackage

// File: rtl/tmds_qm_stage.sv
// tmds_qm_stage: transition-minimised word q_m and its ones count, registered per pixel strobe
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic       clk_x5,
    input  logic       resetn,
    input  logic       pix_en,
    input  logic [7:0] d,
    output logic [8:0] q_m,
    output logic [3:0] n1
);
    logic [8:0] qm_c;
    assign qm_c = qm_encode(d);
    always_ff @(posedge clk_x5) begin
        if (!resetn) begin
            q_m <= '0;
            n1  <= '0;
        end else if (pix_en) begin
            q_m <= qm_c;
            n1  <= ones8(qm_c[7:0]);
        end
    end
endmodule

// File: rtl/tmds_encoder.sv
// tmds_encoder: two-stage TMDS encoder with DC balancing; TERC4 data islands when TMDS_TERC4_EN is defined
module tmds_encoder
    import tmds_pkg::*;
(
    input  logic              clk_x5,
    input  logic              resetn,
    input  logic              pix_en,
    input  logic              de,
    input  logic [7:0]        d,
    input  logic [1:0]        c,
    input  logic              island,
    input  logic [3:0]        aux,
    output logic [9:0]        sym,
    output logic [DISP_W-1:0] disp
);
    logic [8:0]        q_m;
    logic [3:0]        n1;
    logic              de_q;
    logic              island_q;
    logic [1:0]        c_q;
    logic [3:0]        aux_q;
    logic [9:0]        blank_sym;
    logic [9:0]        sym_n;
    logic signed [4:0] cnt;
    logic signed [4:0] half;
    logic signed [4:0] bias;
    logic signed [4:0] cnt_n;

    tmds_qm_stage u_qm (
        .clk_x5 (clk_x5),
        .resetn (resetn),
        .pix_en (pix_en),
        .d      (d),
        .q_m    (q_m),
        .n1     (n1)
    );

`ifdef TMDS_TERC4_EN
    assign blank_sym = island_q ? TERC4_SYM[aux_q] : CTRL_SYM[c_q];
`else
    logic unused_island;
    assign unused_island = ^{island_q, aux_q};
    assign blank_sym = CTRL_SYM[c_q];
`endif

    assign cnt  = signed'(disp);
    assign half = signed'({1'b0, n1}) - 5'sd4;
    assign bias = half <<< 1;

    // matching signs of cnt and N1-N0 mean the word must be inverted to pull cnt back
    always_comb begin
        sym_n = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
        cnt_n = q_m[8] ? cnt + bias : cnt - bias;
        if (!de_q) begin
            sym_n = blank_sym;
            cnt_n = '0;
        end else if (cnt != 5'sd0 && bias != 5'sd0) begin
            sym_n = cnt[4] == bias[4] ? {1'b1, q_m[8], ~q_m[7:0]} : {1'b0, q_m[8], q_m[7:0]};
            cnt_n = cnt[4] == bias[4] ? cnt - bias + (q_m[8] ? 5'sd2 : 5'sd0)
                                      : cnt + bias - (q_m[8] ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge clk_x5) begin
        if (!resetn) begin
            de_q     <= 1'b0;
            island_q <= 1'b0;
            c_q      <= '0;
            aux_q    <= '0;
            sym      <= CTRL_SYM[0];
            disp     <= '0;
        end else if (pix_en) begin
            de_q     <= de;
            island_q <= island;
            c_q      <= c;
            aux_q    <= aux;
            sym      <= sym_n;
            disp     <= cnt_n;
        end
    end
endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: random strobed traffic checked every cycle against a ones-counting TMDS model
module tb_tmds_encoder;
    logic       clk_x5 = 1'b0;
    logic       resetn = 1'b0;
    logic       pix_en = 1'b0;
    logic       de = 1'b0;
    logic       island = 1'b0;
    logic [7:0] d = '0;
    logic [1:0] c = '0;
    logic [3:0] aux = '0;
    logic [9:0] sym;
    logic [4:0] disp;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

`ifdef TMDS_TERC4_EN
    localparam bit TERC_EN = 1'b1;
`else
    localparam bit TERC_EN = 1'b0;
`endif
    localparam logic [9:0] CTRL [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };
    localparam logic [9:0] TERC [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
    localparam logic [9:0] ISL_EXP = TERC_EN ? 10'b1010011100 : 10'b0101010100;

    tmds_encoder dut (
        .clk_x5 (clk_x5),
        .resetn (resetn),
        .pix_en (pix_en),
        .de     (de),
        .d      (d),
        .c      (c),
        .island (island),
        .aux    (aux),
        .sym    (sym),
        .disp   (disp)
    );

    always #5 clk_x5 = ~clk_x5;

    // model: inputs held one strobe in p_*, then turned into a symbol at the next strobe
    logic [9:0] m_sym;
    int         m_cnt;
    logic       p_de, p_isl;
    logic [7:0] p_d;
    logic [1:0] p_c;
    logic [3:0] p_aux;
    int         n1d, n1;
    logic       xn, inv;
    logic [8:0] qm;

    always @(posedge clk_x5) begin
        if (!resetn) begin
            m_sym = CTRL[0];
            m_cnt = 0;
            p_de = 0; p_isl = 0; p_d = '0; p_c = '0; p_aux = '0;
        end else if (pix_en) begin
            if (!p_de) begin
                m_sym = (TERC_EN && p_isl) ? TERC[p_aux] : CTRL[p_c];
                m_cnt = 0;
            end else begin
                n1d = $countones(p_d);
                xn = n1d > 4 || (n1d == 4 && !p_d[0]);
                for (int i = 0; i < 8; i++)
                    qm[i] = (^(p_d & 8'((1 << (i + 1)) - 1))) ^ (xn && (i % 2 == 1));
                qm[8] = !xn;
                n1 = $countones(qm[7:0]);
                inv = (m_cnt == 0 || n1 == 4) ? !qm[8]
                    : ((m_cnt > 0 && n1 > 4) || (m_cnt < 0 && n1 < 4));
                m_sym = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
                m_cnt = m_cnt + 2 * $countones(m_sym) - 10;
            end
            p_de = de; p_isl = island; p_d = d; p_c = c; p_aux = aux;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_x5) begin
        if (chk_en) begin
            check("model_sym", int'(sym), int'(m_sym));
            check("model_disp", $signed(disp), m_cnt);
        end
    end

    task automatic strobe(input logic e, input logic [7:0] dd, input logic [1:0] cc,
                          input logic isl, input logic [3:0] ax, input int gap);
        de = e; d = dd; c = cc; island = isl; aux = ax; pix_en = 1'b1;
        @(posedge clk_x5); #1;
        pix_en = 1'b0;
        repeat (gap) begin
            {de, d, c, island, aux} = 16'($urandom);
            @(posedge clk_x5); #1;
        end
    endtask

    logic [15:0] stim [26];
    logic [9:0]  ref_q [$];

    initial begin
        resetn = 1'b0;
        pix_en = 1'b1;
        @(posedge clk_x5); #1;
        chk_en = 1'b1;
        @(posedge clk_x5); #1;
        check("reset_sym", int'(sym), 10'b1101010100);
        check("reset_disp", $signed(disp), 0);
        resetn = 1'b1;
        strobe(1'b0, 8'h00, 2'b01, 1'b0, 4'h0, 0);
        check("post_reset_ctrl", int'(sym), 10'b1101010100);
        strobe(1'b0, 8'h00, 2'b01, 1'b0, 4'h0, 0);
        check("ctrl01_sym", int'(sym), 10'b0010101011);
        check("ctrl01_disp", $signed(disp), 0);
        strobe(1'b1, 8'h00, 2'b00, 1'b0, 4'h0, 0);
        strobe(1'b1, 8'h00, 2'b00, 1'b0, 4'h0, 0);
        check("bal_first_sym", int'(sym), 10'b0100000000);
        check("bal_first_disp", $signed(disp), -8);
        strobe(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 0);
        check("bal_second_sym", int'(sym), 10'b1111111111);
        check("bal_second_disp", $signed(disp), 2);
        strobe(1'b1, 8'h00, 2'b00, 1'b0, 4'h0, 0);
        check("de_drop_sym", int'(sym), 10'b1101010100);
        check("de_drop_disp", $signed(disp), 0);
        strobe(1'b0, 8'h00, 2'b10, 1'b1, 4'h0, 0);
        check("after_drop_sym", int'(sym), 10'b0100000000);
        check("after_drop_disp", $signed(disp), -8);
        strobe(1'b0, 8'h00, 2'b10, 1'b0, 4'h0, 0);
        check("island_sym", int'(sym), int'(ISL_EXP));
        check("island_disp", $signed(disp), 0);

        repeat (300)
            strobe($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom), 1'($urandom),
                   4'($urandom), $urandom_range(0, 5));

        resetn = 1'b0;
        pix_en = 1'b0;
        @(posedge clk_x5); #1;
        check("mid_reset_sym", int'(sym), 10'b1101010100);
        check("mid_reset_disp", $signed(disp), 0);
        resetn = 1'b1;
        strobe(1'b1, 8'hA5, 2'b11, 1'b0, 4'h0, 0);
        check("first_post_rst_sym", int'(sym), 10'b1101010100);

        for (int i = 0; i < 26; i++) begin
            stim[i] = 16'($urandom);
            stim[i][15] = (i >= 2) && (i % 7 != 0);
        end
        for (int r = 0; r < 2; r++) begin
            resetn = 1'b0;
            @(posedge clk_x5); #1;
            resetn = 1'b1;
            for (int i = 0; i < 26; i++) begin
                strobe(stim[i][15], stim[i][14:7], stim[i][6:5], stim[i][4], stim[i][3:0],
                       r == 0 ? 0 : 4);
                if (r == 0) ref_q.push_back(m_sym);
                else check("rate_seq", int'(sym), int'(ref_q[i]));
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
